square_draw_scheduler: RTL and testbench

Time-shares the single VGA adapter plot port among up to NUM_REQ drawing requesters, such as the note lane, hit marker and erase/background painters. Each request is a 4x4 square: position plus colour. A round-robin arbiter grants one requester at a time. The block then sweeps the 16 pixels of the granted square onto x/y/colour/plot, one pixel per clock. It sits between the game logic and vga_adapter at 160x120, 3-bit colour, and is the only driver of the adapter's plot inputs.

---
 rtl/square_draw_scheduler_pkg.sv | 15 +
 rtl/square_draw_scheduler_rr_arbiter.sv | 35 +++
 rtl/square_draw_scheduler.sv | 150 +++++++++++++++
 tb/tb_square_draw_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/square_draw_scheduler_pkg.sv
// Shared screen geometry, field widths and FSM encoding for the square draw scheduler.
package square_draw_scheduler_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_e;

endpackage

// File: rtl/square_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_winner+1 and wraps mod NUM_REQ.
module square_draw_scheduler_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx
);

  int         cand;
  logic [IDX_W-1:0] cand_idx;
  logic       found;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_winner) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found               = 1'b1;
        winner_idx          = cand_idx;
        winner_oh[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_draw_scheduler.sv
// Arbitrates drawing requesters and sweeps each granted SIDE x SIDE square onto the VGA plot port.
module square_draw_scheduler
  import square_draw_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SIDE    = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [X_W*NUM_REQ-1:0]       req_x,
  input  logic [Y_W*NUM_REQ-1:0]       req_y,
  input  logic [COLOUR_W*NUM_REQ-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot
);

  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int LOG_SIDE = $clog2(SIDE);
  localparam int OFF_W    = 2 * LOG_SIDE;
  localparam int SX_W     = X_W + 1;
  localparam int SY_W     = Y_W + 1;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SIDE * SIDE - 1);

  state_e                state_q, state_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [X_W-1:0]        base_x_q, base_x_d;
  logic [Y_W-1:0]        base_y_q, base_y_d;
  logic [COLOUR_W-1:0]   col_q, col_d;
  logic [NUM_REQ-1:0]    win_oh_q, win_oh_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  busy_q, busy_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  plot_q, plot_d;

  logic [NUM_REQ-1:0]    arb_oh;
  logic [IDX_W-1:0]      arb_idx;
  logic [SX_W-1:0]       sum_x;
  logic [SY_W-1:0]       sum_y;

  square_draw_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req),
    .last_winner(last_q),
    .winner_oh  (arb_oh),
    .winner_idx (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    last_d   = last_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    col_d    = col_q;
    win_oh_d = win_oh_q;
    grant_d  = '0;
    done_d   = '0;
    busy_d   = busy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    // Wide sums so off-screen pixels are recognised before truncation to the port widths.
    sum_x = SX_W'(base_x_q) + SX_W'(off_q[LOG_SIDE-1:0]);
    sum_y = SY_W'(base_y_q) + SY_W'(off_q[OFF_W-1:LOG_SIDE]);

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          base_x_d = req_x[int'(arb_idx)*X_W +: X_W];
          base_y_d = req_y[int'(arb_idx)*Y_W +: Y_W];
          col_d    = req_colour[int'(arb_idx)*COLOUR_W +: COLOUR_W];
          off_d    = '0;
          last_d   = arb_idx;
          win_oh_d = arb_oh;
          grant_d  = arb_oh;
          busy_d   = 1'b1;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        busy_d   = 1'b1;
        x_d      = sum_x[X_W-1:0];
        y_d      = sum_y[Y_W-1:0];
        colour_d = col_q;
        plot_d   = (sum_x < SX_W'(SCREEN_W)) && (sum_y < SY_W'(SCREEN_H));
        off_d    = off_q + 1'b1;
        if (off_q == OFF_LAST) begin
          done_d  = win_oh_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      off_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      base_x_q <= '0;
      base_y_q <= '0;
      col_q    <= '0;
      win_oh_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      off_q    <= off_d;
      last_q   <= last_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      col_q    <= col_d;
      win_oh_q <= win_oh_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_square_draw_scheduler.sv
// Directed bench: single square, clipping/truncation, latched data, round-robin order, mid-square reset.
module tb_square_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_x = '0;
  logic [27:0] req_y = '0;
  logic [11:0] req_colour = '0;
  logic [3:0]  grant, done;
  logic        busy, plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  int n_pass  = 0;
  int n_total = 0;

  square_draw_scheduler #(.NUM_REQ(4), .SIDE(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_colour(req_colour),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int px, input int py, input int c);
    req_x[8*i +: 8]      = 8'(px);
    req_y[7*i +: 7]      = 7'(py);
    req_colour[3*i +: 3] = 3'(c);
  endtask

  // Expected pixel k of a square at (bx,by): row-major, clipped against 160x120 before truncation.
  task automatic check_pixel(input string tag, input int k, input int bx, input int by,
                             input int c, input logic [3:0] done_exp);
    int         ex, ey;
    logic [7:0] ex8;
    logic [6:0] ey7;
    logic [2:0] c3;
    logic       ep;
    ex  = bx + (k % 4);
    ey  = by + (k / 4);
    ep  = (ex < 160) && (ey < 120);
    ex8 = 8'(ex);
    ey7 = 7'(ey);
    c3  = 3'(c);
    check($sformatf("%s[%0d]", tag, k), {grant, x, y, colour, plot, done, busy},
          {4'b0000, ex8, ey7, c3, ep, done_exp, 1'b1});
  endtask

  initial begin
    // Reset state
    #1 resetn = 1'b0;
    #2;
    check("reset_out", {grant, done, busy, x, y, colour, plot}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;

    // Single request from requester 0
    set_req(0, 10, 20, 4);
    req = 4'b0001;
    tick();
    check("t1_grant", {grant, busy, plot}, {4'b0001, 1'b1, 1'b0});
    req = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_pixel("t1_px", k, 10, 20, 4, (k == 15) ? 4'b0001 : 4'b0000);
    end
    tick();
    check("t1_idle", {grant, done, busy, plot}, 32'd0);

    // Clipping at the corner, data changed after grant, requester 2 withdraws before its grant
    set_req(1, 158, 118, 5);
    set_req(2, 40, 40, 6);
    req = 4'b0110;
    tick();
    check("t2_grant", {grant, busy, plot}, {4'b0010, 1'b1, 1'b0});
    req = 4'b0100;
    tick();
    check_pixel("t2_px", 0, 158, 118, 5, 4'b0000);
    set_req(1, 0, 0, 0);
    req = 4'b0000;
    for (int k = 1; k < 16; k++) begin
      tick();
      check_pixel("t2_px", k, 158, 118, 5, (k == 15) ? 4'b0010 : 4'b0000);
    end
    tick();
    check("t2_withdrawn", {grant, busy}, 32'd0);

    // Coordinates past 255/127 truncate and never plot
    set_req(2, 254, 127, 7);
    req = 4'b0100;
    tick();
    check("t3_grant", {grant, busy, plot}, {4'b0100, 1'b1, 1'b0});
    req = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_pixel("t3_px", k, 254, 127, 7, (k == 15) ? 4'b0100 : 4'b0000);
    end
    tick();
    check("t3_idle", {grant, busy}, 32'd0);

    // All four requesting continuously from reset
    for (int i = 0; i < 4; i++) set_req(i, 20 * i, 10 * i, i + 1);
    req    = 4'b1111;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr_grant%0d", g), {grant, busy, plot}, {4'(1 << g), 1'b1, 1'b0});
      for (int k = 0; k < 16; k++) begin
        tick();
        check_pixel($sformatf("rr%0d_px", g), k, 20 * g, 10 * g, g + 1,
                    (k == 15) ? 4'(1 << g) : 4'b0000);
      end
      tick();
    end
    check("rr_wrap", {grant, busy, plot}, {4'b0001, 1'b1, 1'b0});

    // Reset in cycle 8 of a square, then requester 1 first, then 3 (no back-to-back re-grant)
    req = 4'b1010;
    repeat (7) tick();
    resetn = 1'b0;
    #1;
    check("mid_reset", {grant, done, busy, x, y, colour, plot}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("post_reset_grant", {grant, busy, plot}, {4'b0010, 1'b1, 1'b0});
    for (int k = 0; k < 16; k++) begin
      tick();
      check_pixel("pr1_px", k, 20, 10, 2, (k == 15) ? 4'b0010 : 4'b0000);
    end
    tick();
    check("no_back_to_back", {grant, busy, plot}, {4'b1000, 1'b1, 1'b0});
    req = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_pixel("pr3_px", k, 60, 30, 4, (k == 15) ? 4'b1000 : 4'b0000);
    end
    tick();
    check("final_idle", {grant, done, busy, plot}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
